adder_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bit adder: adds two WIDTH-bit operands plus carry-in over STAGES register stages, one carry-chunk per stage, with valid/ready flow control on both sides. Throughput is one addition per cycle; latency is STAGES cycles. It serves as the datapath adder for wide accumulators and counters where a single-cycle ripple carry misses timing.

---
 rtl/adder_pipe_pkg.sv | 27 ++
 rtl/adder_pipe_chunk.sv | 14 +
 rtl/adder_pipe.sv | 104 ++++++++++
 tb/tb_adder_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared types for adder_pipe: chunk sizing and the per-stage pipeline register.
// Sign-bit fields exist only when ADDER_PIPE_OVF_EN is defined.
package adder_pipe_pkg;

  // Upper bound on WIDTH; stage registers are sized to this and trimmed by synthesis.
  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [MaxWidth-1:0] sum;   // chunks resolved so far
    logic [MaxWidth-1:0] op_a;  // operand bits not yet consumed
    logic [MaxWidth-1:0] op_b;
`ifdef ADDER_PIPE_OVF_EN
    logic                sign_a;
    logic                sign_b;
`endif
  } stage_t;

  localparam stage_t StageRst = '0;

endpackage

// File: rtl/adder_pipe_chunk.sv
// adder_chunk: combinational Width-bit adder with carry-in and carry-out.
module adder_chunk #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic             i_cin,
  output logic [Width-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{Width{1'b0}}, i_cin};

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit adder resolved one carry chunk per stage over STAGES registered stages,
// valid/ready on both sides. Define ADDER_PIPE_OVF_EN to add the signed-overflow output out_ovf.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned Chunk = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0 || WIDTH > MaxWidth) begin : g_param_check
    $error("adder_pipe: WIDTH must be a multiple of STAGES (STAGES >= 1, WIDTH <= MaxWidth)");
  end

  stage_t w_src   [STAGES];
  stage_t w_next  [STAGES];
  stage_t r_stage [STAGES];
  logic   w_en;

  // The whole pipe moves in lockstep; only a stalled valid result can block it.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [Chunk-1:0] w_chunk_sum;
    logic             w_chunk_cout;

    if (k == 0) begin : g_head
      always_comb begin
        w_src[k]                 = StageRst;
        w_src[k].valid           = in_valid;
        w_src[k].carry           = in_cin;
        w_src[k].op_a[WIDTH-1:0] = in_a;
        w_src[k].op_b[WIDTH-1:0] = in_b;
`ifdef ADDER_PIPE_OVF_EN
        w_src[k].sign_a          = in_a[WIDTH-1];
        w_src[k].sign_b          = in_b[WIDTH-1];
`endif
      end
    end else begin : g_body
      always_comb begin
        w_src[k] = r_stage[k-1];
      end
    end

    adder_chunk #(
      .Width (Chunk)
    ) u_chunk (
      .i_a    (w_src[k].op_a[k*Chunk +: Chunk]),
      .i_b    (w_src[k].op_b[k*Chunk +: Chunk]),
      .i_cin  (w_src[k].carry),
      .o_sum  (w_chunk_sum),
      .o_cout (w_chunk_cout)
    );

    // Consumed operand chunks are cleared so dead bits do not ripple down the pipe.
    always_comb begin
      w_next[k]                        = w_src[k];
      w_next[k].carry                  = w_chunk_cout;
      w_next[k].sum[k*Chunk +: Chunk]  = w_chunk_sum;
      w_next[k].op_a[k*Chunk +: Chunk] = '0;
      w_next[k].op_b[k*Chunk +: Chunk] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage[k] <= StageRst;
      end else if (w_en) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  assign out_valid = r_stage[STAGES-1].valid;
  assign out_sum   = r_stage[STAGES-1].sum[WIDTH-1:0];
  assign out_cout  = r_stage[STAGES-1].carry;

`ifdef ADDER_PIPE_OVF_EN
  assign out_ovf = (r_stage[STAGES-1].sign_a == r_stage[STAGES-1].sign_b) &&
                   (r_stage[STAGES-1].sum[WIDTH-1] != r_stage[STAGES-1].sign_a);
`endif

  logic unused_tail;
  assign unused_tail = ^{r_stage[STAGES-1].op_a, r_stage[STAGES-1].op_b,
                         r_stage[STAGES-1].sum};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=16, STAGES=4); checks out_ovf when
// ADDER_PIPE_OVF_EN is defined.
module tb_adder_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 4;
  localparam int unsigned NV = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADDER_PIPE_OVF_EN
  logic         out_ovf;
`endif

  adder_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          sent;
    int          recv;
    logic        held_v;
    logic [W:0]  held;
    logic [W:0]  exp_q [$];

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h00F0, 16'h0010, 1'b1, 16'h0101, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_sum", out_sum, 0);
    check("reset out_cout", out_cout, 0);
    check("reset in_ready", in_ready, 1);
`ifdef ADDER_PIPE_OVF_EN
    check("reset out_ovf", out_ovf, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle out_valid", out_valid, 0);
      check("idle out_sum", out_sum, 0);
      check("idle in_ready", in_ready, 1);
    end

    // Single beats: latency, arithmetic and carry propagation across chunks.
    for (int i = 0; i < NV; i++) begin
      in_valid  = 1'b1;
      in_a      = vecs[i].a;
      in_b      = vecs[i].b;
      in_cin    = vecs[i].cin;
      out_ready = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        cyc++;
      end while (!out_valid && cyc < 20);
      check($sformatf("vec%0d latency", i), cyc, S);
      check($sformatf("vec%0d out_sum", i), out_sum, vecs[i].sum);
      check($sformatf("vec%0d out_cout", i), out_cout, vecs[i].cout);
`ifdef ADDER_PIPE_OVF_EN
      check($sformatf("vec%0d out_ovf", i), out_ovf, vecs[i].ovf);
`endif
      @(negedge clk);
      check($sformatf("vec%0d consumed once", i), out_valid, 0);
    end

    // Random stream with random backpressure against an in-order scoreboard.
    sent   = 0;
    recv   = 0;
    held_v = 1'b0;
    held   = '0;
    for (int c = 0; c < 3000 && recv < 100; c++) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("stream in_ready==en", in_ready, !out_valid || out_ready);
      if (held_v) begin
        check("stall hold out_valid", out_valid, 1);
        check("stall hold data", {out_cout, out_sum}, held);
      end
      held_v = out_valid && !out_ready;
      held   = {out_cout, out_sum};
      if (out_valid && out_ready) begin
        check("stream result expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("stream result", {out_cout, out_sum}, exp_q.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
        sent++;
      end
      @(negedge clk);
    end
    check("stream received count", recv, 100);
    check("stream leftover", exp_q.size(), 0);

    // Fill the pipe under stall, then reset with beats in flight.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = W'(16'h1111 * (i + 1));
      in_b     = 16'h0001;
      in_cin   = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stalled out_valid", out_valid, 1);
    check("stalled out_sum", out_sum, 16'h1112);
    check("stalled in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_sum", out_sum, 0);
    check("async reset out_cout", out_cout, 0);
    check("async reset in_ready", in_ready, 1);
`ifdef ADDER_PIPE_OVF_EN
    check("async reset out_ovf", out_ovf, 0);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post-reset no stale result", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
